fw_config_sequencer: RTL and testbench
======================================

Name: fw_config_sequencer

Overview:
- Loads one firmware image for one datapath building block and streams it onto the shared configId/configData bus. Target blocks include the vector-vector ALU and its siblings.
- Owns the global `tracing` signal. It stays up while the image is being buffered, then drops so the pipeline can drain. The bytes are sent as one unbroken burst, and tracing is then restored.
- Sits between the host/debug-interface byte stream and every building block's config port.

Parameters:
- MAX_BYTES, 20, buffer depth in bytes (MAX_CHAINS*5 for MAX_CHAINS=4).
- DRAIN_CYCLES, 8, cycles `tracing` is held low before the first config byte is sent; must be >= deepest pipeline latency.
- IDLE_ID, 8'hFF, configId value that no block owns; driving it resets every block's byte counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- trace_en  in  1  host request for tracing
- cfg_start  in  1  one-cycle pulse that begins a configuration
- cfg_block_id  in  8  target PERSONAL_CONFIG_ID, sampled on cfg_start
- cfg_len  in  8  byte count, sampled on cfg_start
- cfg_data_valid  in  1  byte-stream valid
- cfg_data  in  8  byte-stream payload
- cfg_data_ready  out  1  byte-stream ready
- tracing  out  1  registered tracing enable to all blocks
- configId  out  8  registered config target id
- configData  out  8  registered config byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the burst completes
- err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset values of outputs: tracing=0, configId=IDLE_ID, configData=0, cfg_data_ready=0, busy=0, done=0, err=0, state=IDLE.
- A reset asserted mid-operation takes effect immediately in any state. The buffer contents are then don't-care.
- States: IDLE, LOAD, DRAIN, SEND, GAP.
- IDLE:
  - tracing <= trace_en (1-cycle latency). configId=IDLE_ID.
  - On cfg_start with 1<=cfg_len<=MAX_BYTES: latch id/len, clear write pointer, go to LOAD.
  - On cfg_start with len 0 or >MAX_BYTES: err pulse on the next cycle; stay in IDLE.
- LOAD:
  - cfg_data_ready=1. Each valid&&ready cycle writes cfg_data to buf[wptr] and increments wptr.
  - Valid gaps are allowed. tracing keeps following trace_en, so tracing is not disturbed while bytes arrive.
  - The byte accepted with wptr==len-1 causes transition to DRAIN. ready deasserts in that same next cycle, so no extra byte is accepted.
- DRAIN:
  - tracing=0, configId=IDLE_ID. A counter runs DRAIN_CYCLES cycles, then the state moves to SEND with rptr=0.
- SEND:
  - Exactly len consecutive cycles of configId=latched id, configData=buf[rptr], incrementing rptr.
  - The burst is never interrupted, because target blocks increment their byte counter every cycle their id is present.
  - After rptr==len-1, go to GAP.
- GAP:
  - One cycle of configId=IDLE_ID, tracing=0. This forces the target's counter to reset even if the next job uses the same id.
  - Then go to IDLE with done=1 for that first IDLE cycle. tracing follows trace_en from that cycle, visible one cycle later.
- The configId output is IDLE_ID whenever tracing=1.
- cfg_start while busy=1 is ignored, with no err.
- cfg_data_valid outside LOAD is ignored; ready is 0.
- Timing, with cfg_start at cycle 0 and no stalls: bytes are accepted in cycles 1..len; DRAIN occupies cycles len+1..len+DRAIN_CYCLES; SEND follows for len cycles; then GAP; then done.
- Pointers are $clog2(MAX_BYTES+1) bits wide. The pointers and the DRAIN counter use no wrap-around; they are cleared on state entry.

Decomposition:
- Package fw_config_pkg: state enum (IDLE, LOAD, DRAIN, SEND, GAP) and the IDLE_ID default constant.
- Sub-module cfg_byte_buffer: MAX_BYTES x 8 register array with a write port (we, waddr, wdata) and a combinational read (raddr → rdata). The sequencer owns the pointers and the FSM.

Test Plan:
- Basic load: trace_en=1; start id=3 len=4; bytes A1,A2,A3,A4 back-to-back → tracing=1 through LOAD, then 0 for 8 cycles; configId=3 with data A1..A4 on 4 consecutive cycles; then 1 cycle of FF; done pulse; tracing=1 one cycle after done.
- Stalled stream: id=0 len=20, valid toggled 1/0 randomly → SEND burst is still 20 contiguous cycles in order; ready=0 after the 20th byte; a 21st valid byte is not consumed.
- Bad start: cfg_start with len=0, then len=21 → err pulse each time; busy stays 0; configId stays FF; tracing follows trace_en.
- Same id twice: two jobs for id=2 (len=5 each) → an FF cycle separates the bursts; each burst has exactly 5 id=2 cycles.
- Start while busy: second cfg_start during DRAIN → ignored; no err; the first job completes unchanged.
- Reset mid-SEND: assert rst on the 3rd SEND cycle → configId=FF, tracing=0, busy=0 immediately; after release, a fresh job completes correctly.

Source files
------------

// File: rtl/fw_config_sequencer_pkg.sv
// Shared types for the firmware config sequencer: FSM state encoding and the
// configId value that no building block owns.
package fw_config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam logic [7:0] IDLE_ID_DEFAULT = 8'hFF;

endpackage

// File: rtl/fw_config_sequencer_if.sv
// Host byte stream plus the shared config bus seen by every building block.
interface fw_config_sequencer_if;

    logic       trace_en;
    logic       cfg_start;
    logic [7:0] cfg_block_id;
    logic [7:0] cfg_len;
    logic       cfg_data_valid;
    logic [7:0] cfg_data;
    logic       cfg_data_ready;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output trace_en, cfg_start, cfg_block_id, cfg_len, cfg_data_valid, cfg_data,
        input  cfg_data_ready, tracing, configId, configData, busy, done, err
    );

    modport slave (
        input  trace_en, cfg_start, cfg_block_id, cfg_len, cfg_data_valid, cfg_data,
        output cfg_data_ready, tracing, configId, configData, busy, done, err
    );

endinterface

// File: rtl/fw_config_sequencer_cfg_byte_buffer.sv
// Image buffer: one synchronous write port, one combinational read port.
module cfg_byte_buffer #(
    parameter int MAX_BYTES = 20,
    parameter int ADDR_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MAX_BYTES);

    logic [7:0] r_mem [MAX_BYTES];

    // NOTE: the array has no reset; every byte is written in LOAD before SEND reads it.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr < DEPTH) ? r_mem[i_raddr] : 8'h00;

endmodule

// File: rtl/fw_config_sequencer.sv
// Buffers one firmware image, drops tracing to drain the pipeline, then streams
// the image as one unbroken burst on configId/configData.
module fw_config_sequencer
    import fw_config_pkg::*;
#(
    parameter int         MAX_BYTES    = 20,
    parameter int         DRAIN_CYCLES = 8,
    parameter logic [7:0] IDLE_ID      = IDLE_ID_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    fw_config_sequencer_if.slave   bus
);

    localparam int                PTR_W      = $clog2(MAX_BYTES + 1);
    localparam int                CNT_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [7:0]        MAX_LEN    = 8'(MAX_BYTES);

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_id;
    logic [PTR_W-1:0] r_last;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_drain_cnt;
    logic             r_tracing;
    logic [7:0]       r_config_id;
    logic [7:0]       r_config_data;
    logic             r_done;
    logic             r_err;

    logic             w_ready;
    logic             w_we;
    logic             w_len_ok;
    logic             w_next_tracing;
    logic [PTR_W-1:0] w_raddr;
    logic [7:0]       w_rdata;

    assign w_len_ok = (bus.cfg_len != 8'd0) && (bus.cfg_len <= MAX_LEN);
    assign w_ready  = (r_state == ST_LOAD);
    assign w_we     = w_ready && bus.cfg_data_valid;
    // Look one byte ahead so the registered configData lines up with the SEND cycle.
    assign w_raddr  = (r_state == ST_SEND) ? (r_rptr + PTR_ONE) : '0;

    cfg_byte_buffer #(
        .MAX_BYTES (MAX_BYTES),
        .ADDR_W    (PTR_W)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (bus.cfg_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.cfg_start && w_len_ok)  w_next_state = ST_LOAD;
            ST_LOAD:  if (w_we && (r_wptr == r_last)) w_next_state = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == DRAIN_LAST)  w_next_state = ST_SEND;
            ST_SEND:  if (r_rptr == r_last)           w_next_state = ST_GAP;
            ST_GAP:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase

        // Tracing only follows the host while staying inside IDLE/LOAD.
        w_next_tracing = 1'b0;
        if (((r_state == ST_IDLE) || (r_state == ST_LOAD)) &&
            ((w_next_state == ST_IDLE) || (w_next_state == ST_LOAD))) begin
            w_next_tracing = bus.trace_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id          <= IDLE_ID;
            r_last        <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_drain_cnt   <= '0;
            r_tracing     <= 1'b0;
            r_config_id   <= IDLE_ID;
            r_config_data <= 8'h00;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && bus.cfg_start && w_len_ok) begin
                r_id   <= bus.cfg_block_id;
                r_last <= PTR_W'(bus.cfg_len - 8'd1);
            end
            r_wptr      <= (r_state != ST_LOAD)  ? '0 : (w_we ? r_wptr + PTR_ONE : r_wptr);
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + CNT_ONE : '0;
            r_rptr      <= (r_state == ST_SEND)  ? r_rptr + PTR_ONE : '0;

            r_tracing     <= w_next_tracing;
            r_config_id   <= (w_next_state == ST_SEND) ? r_id    : IDLE_ID;
            r_config_data <= (w_next_state == ST_SEND) ? w_rdata : 8'h00;
            r_done        <= (r_state == ST_GAP);
            r_err         <= (r_state == ST_IDLE) && bus.cfg_start && !w_len_ok;
        end
    end

    assign bus.cfg_data_ready = w_ready;
    assign bus.tracing        = r_tracing;
    assign bus.configId       = r_config_id;
    assign bus.configData     = r_config_data;
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.done           = r_done;
    assign bus.err            = r_err;

endmodule

// File: tb/tb_fw_config_sequencer.sv
// Directed bench for fw_config_sequencer: a job-timeline model checked every
// cycle, plus literal expectations at hand-computed cycles.
module tb_fw_config_sequencer;

    localparam int         MAXB  = 20;
    localparam int         DRAIN = 8;
    localparam logic [7:0] IDLE  = 8'hFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    fw_config_sequencer_if bus();

    fw_config_sequencer #(
        .MAX_BYTES    (MAXB),
        .DRAIN_CYCLES (DRAIN),
        .IDLE_ID      (IDLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: a job is described by when its load finished (m_post); every later
    // output follows from offsets against that cycle.
    bit         m_loading;
    int         m_acc;
    int         m_len;
    int         m_post;
    logic [7:0] m_id;
    logic [7:0] m_bytes[$];
    bit         m_prev_te;
    bit         m_err_pend;

    always @(negedge clk) begin : compare
        int         k;
        bit         in_win, in_send, exp_busy, exp_done, len_ok;
        logic [7:0] exp_id;
        if (rst) begin
            m_loading  = 1'b0;
            m_acc      = 0;
            m_len      = 0;
            m_post     = -1;
            m_prev_te  = 1'b0;
            m_err_pend = 1'b0;
        end
        k        = cyc - m_post;
        in_win   = (m_post >= 0) && (k >= 0) && (k <= DRAIN + m_len + 1);
        in_send  = (m_post >= 0) && (k >= DRAIN) && (k < DRAIN + m_len);
        exp_busy = m_loading || ((m_post >= 0) && (k < DRAIN + m_len + 1));
        exp_done = (m_post >= 0) && (k == DRAIN + m_len + 1);
        exp_id   = in_send ? m_id : IDLE;

        check("ready",   {7'b0, bus.cfg_data_ready}, {7'b0, m_loading});
        check("busy",    {7'b0, bus.busy},           {7'b0, exp_busy});
        check("done",    {7'b0, bus.done},           {7'b0, exp_done});
        check("err",     {7'b0, bus.err},            {7'b0, m_err_pend});
        check("tracing", {7'b0, bus.tracing},        {7'b0, (in_win ? 1'b0 : m_prev_te)});
        check("configId", bus.configId, exp_id);
        if (in_send) check("configData", bus.configData, m_bytes[k - DRAIN]);

        if (!rst) begin
            if (exp_done) m_post = -1;
            len_ok     = (int'(bus.cfg_len) >= 1) && (int'(bus.cfg_len) <= MAXB);
            m_err_pend = !exp_busy && bus.cfg_start && !len_ok;
            if (!exp_busy && bus.cfg_start && len_ok) begin
                m_loading = 1'b1;
                m_acc     = 0;
                m_len     = int'(bus.cfg_len);
                m_id      = bus.cfg_block_id;
                m_bytes.delete();
            end else if (m_loading && bus.cfg_data_valid) begin
                m_bytes.push_back(bus.cfg_data);
                m_acc++;
                if (m_acc == m_len) begin
                    m_loading = 1'b0;
                    m_post    = cyc + 1;
                end
            end
            m_prev_te = bus.trace_en;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int t);
        while (cyc < t) step();
    endtask

    task automatic at_cycle(input int t);
        goto_cycle(t);
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] id, input logic [7:0] len);
        bus.cfg_start    = 1'b1;
        bus.cfg_block_id = id;
        bus.cfg_len      = len;
        step();
        bus.cfg_start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.cfg_data_valid = 1'b1;
        bus.cfg_data       = d;
        step();
        bus.cfg_data_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int s, l, b, iters, i;
        bus.trace_en       = 1'b0;
        bus.cfg_start      = 1'b0;
        bus.cfg_block_id   = 8'h00;
        bus.cfg_len        = 8'h00;
        bus.cfg_data_valid = 1'b0;
        bus.cfg_data       = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        bus.trace_en = 1'b1;
        step();
        step();

        // Basic load: id=3, four back-to-back bytes
        s = cyc;
        pulse_start(8'd3, 8'd4);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        at_cycle(s + 5);
        check("lit_basic_ready_off", {7'b0, bus.cfg_data_ready}, 8'h00);
        check("lit_basic_trace_drop", {7'b0, bus.tracing}, 8'h00);
        at_cycle(s + 12);
        check("lit_basic_drain_id", bus.configId, 8'hFF);
        at_cycle(s + 13);
        check("lit_basic_first_id", bus.configId, 8'h03);
        check("lit_basic_first_data", bus.configData, 8'hA1);
        at_cycle(s + 16);
        check("lit_basic_last_data", bus.configData, 8'hA4);
        at_cycle(s + 17);
        check("lit_basic_gap_id", bus.configId, 8'hFF);
        at_cycle(s + 18);
        check("lit_basic_done", {7'b0, bus.done}, 8'h01);
        at_cycle(s + 19);
        check("lit_basic_trace_back", {7'b0, bus.tracing}, 8'h01);
        step();

        // Stalled stream: id=0, 20 bytes with random valid gaps, then a 21st byte
        s = cyc;
        pulse_start(8'd0, 8'd20);
        i = 0;
        iters = 0;
        while (i < 20) begin
            if ($urandom_range(1) == 1 || iters >= 40) begin
                bus.cfg_data_valid = 1'b1;
                bus.cfg_data       = 8'h40 + 8'(i);
                i++;
            end else begin
                bus.cfg_data_valid = 1'b0;
            end
            iters++;
            step();
        end
        l = cyc - 1;
        bus.cfg_data_valid = 1'b1;
        bus.cfg_data       = 8'hEE;
        at_cycle(l + 1);
        check("lit_stall_ready_off", {7'b0, bus.cfg_data_ready}, 8'h00);
        step();
        step();
        bus.cfg_data_valid = 1'b0;
        at_cycle(l + 9);
        check("lit_stall_first_data", bus.configData, 8'h40);
        at_cycle(l + 28);
        check("lit_stall_last_data", bus.configData, 8'h53);
        at_cycle(l + 29);
        check("lit_stall_gap_id", bus.configId, 8'hFF);
        at_cycle(l + 30);
        check("lit_stall_done", {7'b0, bus.done}, 8'h01);
        step();

        // Bad starts: len 0 then len 21
        bus.trace_en = 1'b0;
        step();
        b = cyc;
        pulse_start(8'd6, 8'd0);
        at_cycle(b + 1);
        check("lit_bad0_err", {7'b0, bus.err}, 8'h01);
        check("lit_bad0_busy", {7'b0, bus.busy}, 8'h00);
        step();
        bus.trace_en = 1'b1;
        pulse_start(8'd6, 8'd21);
        at_cycle(b + 3);
        check("lit_bad21_err", {7'b0, bus.err}, 8'h01);
        check("lit_bad21_id", bus.configId, 8'hFF);
        at_cycle(b + 4);
        check("lit_bad_trace_follow", {7'b0, bus.tracing}, 8'h01);
        step();

        // Same id twice, second start issued in the done cycle of the first
        s = cyc;
        pulse_start(8'd2, 8'd5);
        for (int j = 0; j < 5; j++) send_byte(8'h10 + 8'(j));
        at_cycle(s + 18);
        check("lit_same1_last_id", bus.configId, 8'h02);
        check("lit_same1_last_data", bus.configData, 8'h14);
        at_cycle(s + 19);
        check("lit_same1_gap_id", bus.configId, 8'hFF);
        step();
        bus.cfg_start    = 1'b1;
        bus.cfg_block_id = 8'd2;
        bus.cfg_len      = 8'd5;
        at_cycle(s + 20);
        check("lit_same1_done", {7'b0, bus.done}, 8'h01);
        step();
        bus.cfg_start = 1'b0;
        for (int j = 0; j < 5; j++) send_byte(8'h20 + 8'(j));
        at_cycle(s + 33);
        check("lit_same2_pre_id", bus.configId, 8'hFF);
        at_cycle(s + 34);
        check("lit_same2_first_data", bus.configData, 8'h20);
        at_cycle(s + 40);
        check("lit_same2_done", {7'b0, bus.done}, 8'h01);
        step();

        // Start while busy (during DRAIN) is ignored
        s = cyc;
        pulse_start(8'd5, 8'd2);
        send_byte(8'h55);
        send_byte(8'h66);
        goto_cycle(s + 5);
        bus.cfg_start    = 1'b1;
        bus.cfg_block_id = 8'd9;
        bus.cfg_len      = 8'd3;
        step();
        bus.cfg_start = 1'b0;
        at_cycle(s + 6);
        check("lit_busy_no_err", {7'b0, bus.err}, 8'h00);
        at_cycle(s + 11);
        check("lit_busy_id", bus.configId, 8'h05);
        check("lit_busy_data", bus.configData, 8'h55);
        at_cycle(s + 14);
        check("lit_busy_done", {7'b0, bus.done}, 8'h01);
        at_cycle(s + 15);
        check("lit_busy_idle_after", {7'b0, bus.busy}, 8'h00);
        step();

        // Reset on the third SEND cycle, then a fresh job
        s = cyc;
        pulse_start(8'd7, 8'd6);
        for (int j = 0; j < 6; j++) send_byte(8'h70 + 8'(j));
        at_cycle(s + 15);
        check("lit_rst_send_data", bus.configData, 8'h70);
        goto_cycle(s + 17);
        rst = 1'b1;
        at_cycle(s + 17);
        check("lit_rst_id", bus.configId, 8'hFF);
        check("lit_rst_tracing", {7'b0, bus.tracing}, 8'h00);
        check("lit_rst_busy", {7'b0, bus.busy}, 8'h00);
        step();
        step();
        rst = 1'b0;
        step();
        s = cyc;
        pulse_start(8'd1, 8'd3);
        send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
        at_cycle(s + 12);
        check("lit_fresh_id", bus.configId, 8'h01);
        check("lit_fresh_first", bus.configData, 8'h31);
        at_cycle(s + 14);
        check("lit_fresh_last", bus.configData, 8'h33);
        at_cycle(s + 16);
        check("lit_fresh_done", {7'b0, bus.done}, 8'h01);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
